// File: rtl/csd_decoder.sv
// CSD-to-binary decoder: reads N_DIGITS CSD digits from memory (one per address,
// digit k weighted 2^k) and accumulates their signed two's-complement value.
// Handshake: start (sampled in idle) -> busy -> single-cycle done with result/err.
// Optional build macro CSD_CHECK_EN: also flag two adjacent nonzero digits in err.
module csd_decoder #(
  parameter int unsigned N_DIGITS = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned OUT_W    = 18
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    rd_en,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic [DATA_W-1:0]       rd_data,
  output logic                    busy,
  output logic                    done,
  output logic signed [OUT_W-1:0] result,
  output logic                    err
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(N_DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                    state_q;
  logic                      rd_en_q;
  logic [ADDR_W-1:0]         rd_addr_q;
  logic                      busy_q;
  logic                      done_q;
  logic signed [OUT_W-1:0]   result_q;
  logic                      err_q;
  logic signed [OUT_W-1:0]   acc_q;
`ifdef CSD_CHECK_EN
  logic                      prev_nz_q;
`endif

  logic                      sample;
  logic [ADDR_W-1:0]         dig_idx;
  logic                      is_pos;
  logic                      is_neg;
  logic                      is_bad;
  logic signed [OUT_W-1:0]   weight;
  logic signed [OUT_W-1:0]   acc_d;
  logic                      err_d;

  // Decode the digit arriving this cycle and form the next accumulator / error.
  always_comb begin
    sample  = 1'b0;
    dig_idx = rd_addr_q;
    // rd_data lags the address by one cycle: RUN cycle k carries digit k-1,
    // DRAIN carries the last digit while rd_addr still holds its index.
    if (state_q == StRun && rd_addr_q != '0) begin
      sample  = 1'b1;
      dig_idx = rd_addr_q - ADDR_W'(1);
    end else if (state_q == StDrain) begin
      sample  = 1'b1;
    end
    is_pos = (rd_data == DATA_W'(1));
    is_neg = (rd_data == '1);
    is_bad = !(is_pos || is_neg || rd_data == '0);
    weight = OUT_W'(1) << dig_idx;
    acc_d  = acc_q;
    err_d  = err_q;
    if (sample) begin
      if (is_pos) begin
        acc_d = acc_q + weight;
      end else if (is_neg) begin
        acc_d = acc_q - weight;
      end
      if (is_bad) begin
        err_d = 1'b1;
      end
`ifdef CSD_CHECK_EN
      if (prev_nz_q && (is_pos || is_neg)) begin
        err_d = 1'b1;
      end
`endif
    end
  end

  // Control FSM with registered handshake, memory-port and result outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      err_q     <= 1'b0;
      acc_q     <= '0;
`ifdef CSD_CHECK_EN
      prev_nz_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StRun;
            acc_q     <= '0;
            err_q     <= 1'b0;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
            busy_q    <= 1'b1;
`ifdef CSD_CHECK_EN
            prev_nz_q <= 1'b0;
`endif
          end
        end
        StRun: begin
          acc_q <= acc_d;
          err_q <= err_d;
`ifdef CSD_CHECK_EN
          if (sample) prev_nz_q <= is_pos || is_neg;
`endif
          if (rd_addr_q == LastIdx) begin
            state_q <= StDrain;
            rd_en_q <= 1'b0;
          end else begin
            rd_addr_q <= rd_addr_q + ADDR_W'(1);
          end
        end
        StDrain: begin
          acc_q    <= acc_d;
          err_q    <= err_d;
          result_q <= acc_d;
          done_q   <= 1'b1;
          state_q  <= StDone;
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign err     = err_q;

endmodule

// File: tb/tb_csd_decoder.sv
// Bench for csd_decoder: registered memory model, cycle-level reference model
// checked every cycle, plus directed runs with hand-computed literal results.
module tb_csd_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        busy;
  logic        done;
  logic [17:0] result;
  logic        err;

  logic [7:0]  mem [16];

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  logic chk_en = 1'b0;

  // Reference model state
  int          cyc = -1;
  logic [17:0] run_val = '0;
  logic        run_err = 1'b0;
  logic [17:0] e_res = '0;
  logic        e_err = 1'b0;
  logic [3:0]  e_addr = '0;

  csd_decoder dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .err     (err)
  );

  always #5 clk = ~clk;

  // One-cycle-latency memory
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] calc_val();
    int s = 0;
    for (int k = 0; k < 16; k++) begin
      if (mem[k] == 8'h01) s += (1 << k);
      else if (mem[k] == 8'hFF) s -= (1 << k);
    end
    return 18'(s);
  endfunction

  function automatic logic calc_err();
    logic e = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (mem[k] != 8'h00 && mem[k] != 8'h01 && mem[k] != 8'hFF) e = 1'b1;
`ifdef CSD_CHECK_EN
      if (k > 0 && (mem[k] == 8'h01 || mem[k] == 8'hFF) &&
          (mem[k-1] == 8'h01 || mem[k-1] == 8'hFF)) e = 1'b1;
`endif
    end
    return e;
  endfunction

  // Model: cyc is the cycle index since the accepted start edge (-1 when idle)
  always @(posedge clk) begin
    if (!reset) begin
      cyc = -1;
      e_addr = '0;
      e_res = '0;
      e_err = 1'b0;
    end else if (cyc < 0) begin
      if (start) begin
        cyc = 0;
        run_val = calc_val();
        run_err = calc_err();
      end
    end else if (cyc == 17) begin
      cyc = -1;
    end else begin
      cyc++;
    end
    if (cyc == 17) begin
      e_res = run_val;
      e_err = run_err;
    end
    if (cyc >= 0 && cyc <= 15) e_addr = 4'(cyc);
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(cyc >= 0));
      chk("rd_en", 32'(rd_en), 32'(cyc >= 0 && cyc <= 15));
      chk("done", 32'(done), 32'(cyc == 17));
      chk("rd_addr", 32'(rd_addr), 32'(e_addr));
      chk("result", 32'(result), 32'(e_res));
      if (cyc < 0 || cyc == 17) chk("err", 32'(err), 32'(e_err));
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic clear_mem();
    for (int k = 0; k < 16; k++) mem[k] = 8'h00;
  endtask

  // Launch one conversion and check latency and literal result/err
  task automatic run_conv(input string name, input logic [17:0] lit_res, input logic lit_err);
    int n = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, " latency"}, 32'(n), 32'd17);
    chk({name, " result"}, 32'(result), 32'(lit_res));
    chk({name, " err"}, 32'(err), 32'(lit_err));
    chk({name, " model"}, 32'(e_res), 32'(lit_res));
    @(negedge clk);
  endtask

  initial begin
    int first;
    int cnt;
    reset = 1'b0;
    start = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst rd_en", 32'(rd_en), 32'd0);
    chk("rst rd_addr", 32'(rd_addr), 32'd0);
    chk("rst result", 32'(result), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // 1
    clear_mem(); mem[0] = 8'h01; mem[2] = 8'h01;
    run_conv("t1", 18'd5, 1'b0);
    // 2
    clear_mem(); mem[0] = 8'hFF; mem[3] = 8'h01;
    run_conv("t2a", 18'd7, 1'b0);
    clear_mem(); mem[0] = 8'hFF;
    run_conv("t2b", 18'h3FFFF, 1'b0);
    // 3
    clear_mem();
    for (int k = 0; k < 16; k += 2) mem[k] = 8'h01;
    run_conv("t3a", 18'h05555, 1'b0);
    clear_mem();
    run_conv("t3b", 18'd0, 1'b0);
    // 4
    clear_mem(); mem[3] = 8'h02; mem[5] = 8'h01;
    run_conv("t4a", 18'd32, 1'b1);
    clear_mem(); mem[15] = 8'hFF; mem[13] = 8'h01;
    run_conv("t4b", 18'h3A000, 1'b0);
    // 5
    clear_mem(); mem[0] = 8'h01; mem[1] = 8'h01;
`ifdef CSD_CHECK_EN
    run_conv("t5", 18'd3, 1'b1);
`else
    run_conv("t5", 18'd3, 1'b0);
`endif

    // 6a: reset mid-run after a nonzero result
    clear_mem(); mem[0] = 8'h01; mem[2] = 8'h01;
    run_conv("t6pre", 18'd5, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    cnt = done_cnt;
    reset = 1'b0;
    @(negedge clk);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort rd_en", 32'(rd_en), 32'd0);
    chk("abort result", 32'(result), 32'd0);
    reset = 1'b1;
    repeat (25) @(negedge clk);
    chk("abort no done", 32'(done_cnt - cnt), 32'd0);

    // 6b: start while busy is ignored
    first = -1;
    cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (n == 3) start = 1'b1;
      if (n == 4) start = 1'b0;
      if (done === 1'b1) begin
        cnt++;
        if (first < 0) first = n;
      end
      @(negedge clk);
    end
    chk("busy start done count", 32'(cnt), 32'd1);
    chk("busy start latency", 32'(first), 32'd17);
    chk("busy start result", 32'(result), 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
